yuv422_packer: RTL and testbench

- Sits directly downstream of CTE in RGB->YUV mode (op_mode=1).
- Consumes the CTE byte stream (out_valid/yuv_out, order U,Y0,V,Y1 repeating) and assembles each group of four bytes into one 32-bit UYVY word.
- Buffers words in a small FIFO and delivers them through a valid/ready handshake.
- Tags the last word of each line and flags lost data, because CTE has no backpressure input.

---
 rtl/yuv422_packer.sv | 155 +++++++++++++++
 tb/tb_yuv422_packer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv422_packer.sv
// ============================================================================
// Module      : yuv422_packer
// Description : Packs the CTE U,Y0,V,Y1 byte stream into 32-bit UYVY words,
//               buffers them in a small FIFO and hands them out via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module yuv422_packer #(
    parameter int DEPTH          = 4,
    parameter int PAIRS_PER_LINE = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     yuv_valid_i,
    input  logic [7:0]               yuv_in_i,
    input  logic                     flush_i,
    input  logic                     pix_ready_i,
    output logic                     pix_valid_o,
    output logic [31:0]              pix_data_o,
    output logic                     line_last_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     almost_full_o,
    output logic                     overflow_o,
    output logic [1:0]               phase_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (PAIRS_PER_LINE > 1) ? $clog2(PAIRS_PER_LINE) : 1;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PAIRS_PER_LINE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_U  = 2'd0,
        S_Y0 = 2'd1,
        S_V  = 2'd2,
        S_Y1 = 2'd3
    } state_e;

    state_e          state_q;
    logic [7:0]      u_q;
    logic [7:0]      y0_q;
    logic [7:0]      v_q;
    logic [CW-1:0]   line_cnt_q;

    logic [31:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] tag_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            overflow_q;

    logic            word_done;
    logic            word_tag;
    logic [31:0]     word_data;
    logic            fifo_pop;
    logic            fifo_push;
    logic            word_drop;

    // flush wins over everything sampled in its cycle, including the Y1 byte
    assign word_done = yuv_valid_i & (state_q == S_Y1) & ~flush_i;
    assign word_tag  = (line_cnt_q == CNT_LAST);
    assign word_data = {u_q, y0_q, v_q, yuv_in_i};
    assign fifo_pop  = (level_q != '0) & pix_ready_i & ~flush_i;
    assign fifo_push = word_done & ((level_q < LVL_FULL) | fifo_pop);
    assign word_drop = word_done & ~fifo_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_U;
            u_q        <= '0;
            y0_q       <= '0;
            v_q        <= '0;
            line_cnt_q <= '0;
        end else if (flush_i) begin
            state_q    <= S_U;
            u_q        <= '0;
            y0_q       <= '0;
            v_q        <= '0;
            line_cnt_q <= '0;
        end else if (yuv_valid_i) begin
            case (state_q)
                S_U: begin
                    u_q     <= yuv_in_i;
                    state_q <= S_Y0;
                end
                S_Y0: begin
                    y0_q    <= yuv_in_i;
                    state_q <= S_V;
                end
                S_V: begin
                    v_q     <= yuv_in_i;
                    state_q <= S_Y1;
                end
                default: begin
                    // Dropped words still count toward the line position
                    state_q    <= S_U;
                    line_cnt_q <= word_tag ? '0 : line_cnt_q + CNT_ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tag_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (fifo_push) begin
                mem_q[wr_ptr_q] <= word_data;
                tag_q[wr_ptr_q] <= word_tag;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
            if (word_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign pix_valid_o   = (level_q != '0);
    assign pix_data_o    = mem_q[rd_ptr_q];
    assign line_last_o   = tag_q[rd_ptr_q] & pix_valid_o;
    assign fifo_level_o  = level_q;
    assign almost_full_o = (level_q >= LVL_AF);
    assign overflow_o    = overflow_q;
    assign phase_o       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_yuv422_packer.sv
// ============================================================================
// Module      : tb_yuv422_packer
// Description : Directed scoreboard bench for yuv422_packer (DEPTH=4, 8 pairs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_yuv422_packer;

    localparam int PPL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        yuv_valid = 1'b0;
    logic [7:0]  yuv_in = 8'h00;
    logic        flush = 1'b0;
    logic        pix_ready = 1'b0;
    logic        pix_valid;
    logic [31:0] pix_data;
    logic        line_last;
    logic [2:0]  fifo_level;
    logic        almost_full;
    logic        overflow;
    logic [1:0]  phase;

    typedef struct packed {
        logic        tag;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          popped = 0;
    int          tags_seen = 0;
    int          popped0;
    int          bph = 0;
    int          lcnt = 0;
    logic [7:0]  bu, by0, bv;

    yuv422_packer #(.DEPTH(4), .PAIRS_PER_LINE(PPL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .yuv_valid_i  (yuv_valid),
        .yuv_in_i     (yuv_in),
        .flush_i      (flush),
        .pix_ready_i  (pix_ready),
        .pix_valid_o  (pix_valid),
        .pix_data_o   (pix_data),
        .line_last_o  (line_last),
        .fifo_level_o (fifo_level),
        .almost_full_o(almost_full),
        .overflow_o   (overflow),
        .phase_o      (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one byte; on the Y1 byte the model forms the expected word and tag
    task automatic send_byte(input logic [7:0] b, input bit keep);
        exp_t e;
        yuv_valid = 1'b1;
        yuv_in    = b;
        case (bph)
            0: bu  = b;
            1: by0 = b;
            2: bv  = b;
            default: begin
                e.tag  = (lcnt == PPL - 1);
                e.data = {bu, by0, bv, b};
                if (keep) sbq.push_back(e);
                lcnt = (lcnt == PPL - 1) ? 0 : lcnt + 1;
            end
        endcase
        bph = (bph + 1) % 4;
        tick();
        yuv_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit keep);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], keep);
            check("phase_step", {30'd0, phase}, (i + 1) % 4);
            if (gap > 0) begin
                repeat (gap) tick();
                check("phase_hold", {30'd0, phase}, (i + 1) % 4);
            end
        end
    endtask

    task automatic do_flush(input bit with_byte, input logic [7:0] b);
        flush = 1'b1;
        if (with_byte) begin
            yuv_valid = 1'b1;
            yuv_in    = b;
        end
        tick();
        flush     = 1'b0;
        yuv_valid = 1'b0;
        sbq.delete();
        bph  = 0;
        lcnt = 0;
        check("flush_phase", {30'd0, phase}, 0);
        check("flush_level", {29'd0, fifo_level}, 0);
        check("flush_ovf", {31'd0, overflow}, 0);
        check("flush_valid", {31'd0, pix_valid}, 0);
    endtask

    task automatic drain();
        pix_ready = 1'b1;
        for (int i = 0; i < 40 && sbq.size() != 0; i++) tick();
        tick();
        check("drain_sb_empty", sbq.size(), 0);
        check("drain_level", {29'd0, fifo_level}, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && !flush && pix_valid && pix_ready) begin
            if (sbq.size() == 0) begin
                errors++;
                $error("FAIL unexpected_word: observed=%0h expected=none", pix_data);
            end else begin
                mon_e = sbq.pop_front();
                check("word_data", pix_data, mon_e.data);
                check("word_tag", {31'd0, line_last}, {31'd0, mon_e.tag});
            end
            popped++;
            if (line_last) tags_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_valid", {31'd0, pix_valid}, 0);
        check("rst_data", pix_data, 0);
        check("rst_last", {31'd0, line_last}, 0);
        check("rst_level", {29'd0, fifo_level}, 0);
        check("rst_af", {31'd0, almost_full}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_phase", {30'd0, phase}, 0);
        rst_n = 1'b1;
        tick();

        // Basic word, one-cycle latency
        pix_ready = 1'b1;
        send_word(32'h80107FEB, 0, 1'b1);
        check("basic_valid", {31'd0, pix_valid}, 1);
        check("basic_data", pix_data, 32'h80107FEB);
        check("basic_last", {31'd0, line_last}, 0);
        check("basic_level", {29'd0, fifo_level}, 1);
        tick();
        check("basic_level_after", {29'd0, fifo_level}, 0);
        check("basic_valid_after", {31'd0, pix_valid}, 0);

        // Gapped input
        send_word(32'h80107FEB, 2, 1'b1);
        drain();

        // Line tag over two lines plus one
        do_flush(1'b0, 8'h00);
        tags_seen = 0;
        for (int w = 1; w <= 17; w++) begin
            send_word({8'(8'h10 + w), 8'(8'h20 + w), 8'(8'h30 + w), 8'(8'h40 + w)}, 0, 1'b1);
        end
        drain();
        check("line_tags", tags_seen, 2);

        // Full / overflow
        do_flush(1'b0, 8'h00);
        pix_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_word(32'hC0C1C200 + i, 0, 1'b1);
            check("fill_level", {29'd0, fifo_level}, i + 1);
            check("fill_af", {31'd0, almost_full}, (i + 1 >= 3) ? 1 : 0);
            check("fill_ovf", {31'd0, overflow}, 0);
        end
        send_word(32'hBAD0BAD0, 0, 1'b0);
        check("drop_ovf", {31'd0, overflow}, 1);
        check("drop_level", {29'd0, fifo_level}, 4);
        send_byte(8'hE1, 1'b1);
        send_byte(8'hE2, 1'b1);
        send_byte(8'hE3, 1'b1);
        pix_ready = 1'b1;
        send_byte(8'hE4, 1'b1);
        check("full_pushpop_level", {29'd0, fifo_level}, 4);
        check("full_pushpop_ovf", {31'd0, overflow}, 1);
        drain();

        // Simultaneous push and pop at level 2
        do_flush(1'b0, 8'h00);
        pix_ready = 1'b0;
        send_word(32'h01020304, 0, 1'b1);
        send_word(32'h05060708, 0, 1'b1);
        check("sim_level_pre", {29'd0, fifo_level}, 2);
        send_byte(8'h09, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h0B, 1'b1);
        pix_ready = 1'b1;
        send_byte(8'h0C, 1'b1);
        check("sim_level", {29'd0, fifo_level}, 2);
        drain();

        // Flush after Y0 with a queued word and a pending pop
        pix_ready = 1'b0;
        send_word(32'hAABBCCDD, 0, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        pix_ready = 1'b1;
        do_flush(1'b1, 8'h55);
        send_word(32'h12345678, 0, 1'b1);
        check("clean_valid", {31'd0, pix_valid}, 1);
        check("clean_data", pix_data, 32'h12345678);
        check("clean_last", {31'd0, line_last}, 0);
        drain();

        // Asynchronous reset mid-word with 3 words queued
        pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_word(32'h99887700 + i, 0, 1'b1);
        check("ar_level_pre", {29'd0, fifo_level}, 3);
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, pix_valid}, 0);
        check("ar_data", pix_data, 0);
        check("ar_last", {31'd0, line_last}, 0);
        check("ar_level", {29'd0, fifo_level}, 0);
        check("ar_af", {31'd0, almost_full}, 0);
        check("ar_ovf", {31'd0, overflow}, 0);
        check("ar_phase", {30'd0, phase}, 0);
        sbq.delete();
        bph  = 0;
        lcnt = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        pix_ready = 1'b1;
        popped0 = popped;
        send_word(32'hDEADBEEF, 0, 1'b1);
        drain();
        check("ar_one_word", popped - popped0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
